spi_rx_fifo: RTL and testbench

- Parametrised SPI slave receive path: synchronises external SCK/MOSI/chip-select into the `clock` domain and shifts WIDTH-bit words in any SPI mode.
- Buffers completed words in a DEPTH-entry first-word-fall-through FIFO.
- Flags completion, overrun and truncated frames to the CPU-side logic that drains it.
- Unlike the earlier receiver, it uses the real SCK edge, has a reset, and loses no words under back-to-back traffic.

---
 rtl/spi_rx_fifo.sv | 172 +++++++++++++++++
 tb/tb_spi_rx_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_fifo.sv
// SPI slave receive path: synchronises SCK/MOSI/select, assembles WIDTH-bit
// words in any SPI mode and queues them in a first-word-fall-through FIFO.
module spi_rx_fifo #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic                     sck,
    input  logic                     mosi,
    input  logic                     slaveChipSelectN,
    input  logic                     rdEn,
    input  logic                     clearOverrun,
    output logic [WIDTH-1:0]         rdData,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     interupt,
    output logic                     overrun,
    output logic                     frameError
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_reg;
    logic [SYNC_STAGES-1:0] csn_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic                   sck_prev_reg;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next, shift_in;
    logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic             word_done;
    logic             frame_err_next;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg, count_next;
    logic             interupt_reg, overrun_reg, frame_error_reg;

    logic sck_s, csn_s, mosi_s;
    logic sck_rise, sck_fall, lead_edge, trail_edge, sample_edge;
    logic pop, push, full, overrun_set;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            sck_sync_reg  <= {SYNC_STAGES{CPOL}};
            csn_sync_reg  <= {SYNC_STAGES{1'b1}};
            mosi_sync_reg <= '0;
            sck_prev_reg  <= CPOL;
        end else begin
            sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], sck};
            csn_sync_reg  <= {csn_sync_reg[SYNC_STAGES-2:0], slaveChipSelectN};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
            sck_prev_reg  <= sck_s;
        end
    end

    assign sck_s  = sck_sync_reg[SYNC_STAGES-1];
    assign csn_s  = csn_sync_reg[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

    assign sck_rise    = sck_s & ~sck_prev_reg;
    assign sck_fall    = ~sck_s & sck_prev_reg;
    // Leading edge leaves the idle level; CPHA picks which of the two samples.
    assign lead_edge   = CPOL ? sck_fall : sck_rise;
    assign trail_edge  = CPOL ? sck_rise : sck_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;

    assign shift_in = MSB_FIRST ? {shift_reg[WIDTH-2:0], mosi_s}
                                : {mosi_s, shift_reg[WIDTH-1:1]};

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_reg       <= IDLE;
            shift_reg       <= '0;
            bit_cnt_reg     <= '0;
            interupt_reg    <= 1'b0;
            frame_error_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            shift_reg       <= shift_next;
            bit_cnt_reg     <= bit_cnt_next;
            interupt_reg    <= word_done;
            frame_error_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        bit_cnt_next   = bit_cnt_reg;
        word_done      = 1'b0;
        frame_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                bit_cnt_next = '0;
                if (!csn_s) state_next = ACTIVE;
            end
            ACTIVE: begin
                if (csn_s) begin
                    state_next     = IDLE;
                    bit_cnt_next   = '0;
                    shift_next     = '0;
                    frame_err_next = (bit_cnt_reg != '0);
                end else if (sample_edge) begin
                    shift_next = shift_in;
                    if (bit_cnt_reg == LAST_BIT) begin
                        bit_cnt_next = '0;
                        word_done    = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A pop frees the head slot in the same cycle, so a full FIFO can still
    // accept a completing word when it is being read.
    assign valid       = (count_reg != '0);
    assign full        = (count_reg == FULL_CNT);
    assign pop         = rdEn & valid;
    assign push        = word_done & (~full | pop);
    assign overrun_set = word_done & full & ~pop;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            if (overrun_set)
                overrun_reg <= 1'b1;
            else if (clearOverrun)
                overrun_reg <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_reg] <= shift_in;
    end

    assign rdData     = valid ? mem[rd_ptr_reg] : '0;
    assign count      = count_reg;
    assign interupt   = interupt_reg;
    assign overrun    = overrun_reg;
    assign frameError = frame_error_reg;

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Bench for spi_rx_fifo: directed SPI frames, scoreboard-checked FIFO pops,
// plus four extra instances sweeping SPI mode and bit order.
`timescale 1ns/1ps
module tb_spi_rx_fifo;

    localparam int HP = 60;  // SCK half-period: 6 clocks
    localparam logic [3:0] M_CPOL = 4'b0110;
    localparam logic [3:0] M_CPHA = 4'b0101;
    localparam logic [3:0] M_MSB  = 4'b0111;

    logic        clock = 1'b0;
    logic        resetN, sck, mosi, csn, rdEn, clearOverrun;
    logic [15:0] rdData;
    logic        valid, interupt, overrun, frameError;
    logic [2:0]  count;

    logic [3:0]  m_sck, m_csn;
    logic        m_mosi;
    logic [15:0] m_rd [4];
    logic        m_valid [4];
    logic [2:0]  m_count [4];
    logic        m_irq [4], m_ovr [4], m_fe [4];

    logic [15:0] exp_q [$];
    logic [15:0] exp_w;
    int n_checks = 0;
    int n_pass   = 0;
    int irq_cnt  = 0;
    int fe_cnt   = 0;
    event last_ev;

    always #5 clock = ~clock;

    spi_rx_fifo dut (
        .clock(clock), .resetN(resetN), .sck(sck), .mosi(mosi),
        .slaveChipSelectN(csn), .rdEn(rdEn), .clearOverrun(clearOverrun),
        .rdData(rdData), .valid(valid), .count(count), .interupt(interupt),
        .overrun(overrun), .frameError(frameError)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_mode
        spi_rx_fifo #(
            .CPOL(M_CPOL[gi]), .CPHA(M_CPHA[gi]), .MSB_FIRST(M_MSB[gi])
        ) u_mode (
            .clock(clock), .resetN(resetN), .sck(m_sck[gi]), .mosi(m_mosi),
            .slaveChipSelectN(m_csn[gi]), .rdEn(1'b0), .clearOverrun(1'b0),
            .rdData(m_rd[gi]), .valid(m_valid[gi]), .count(m_count[gi]),
            .interupt(m_irq[gi]), .overrun(m_ovr[gi]), .frameError(m_fe[gi])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic set_sck(input int tgt, input logic v);
        if (tgt < 0) sck = v; else m_sck[tgt] = v;
    endtask
    task automatic set_csn(input int tgt, input logic v);
        if (tgt < 0) csn = v; else m_csn[tgt] = v;
    endtask
    task automatic set_mosi(input int tgt, input logic v);
        if (tgt < 0) mosi = v; else m_mosi = v;
    endtask

    // Master side: wire order is always MSB of data first.
    task automatic spi_send(input int tgt, input logic cpol, input logic cpha,
                            input logic [15:0] data, input int nbits,
                            input bit start_sel, input bit end_sel);
        logic b;
        if (start_sel) begin set_csn(tgt, 1'b0); #(HP); end
        for (int i = 0; i < nbits; i++) begin
            b = data[15-i];
            if (!cpha) begin
                set_mosi(tgt, b); #(HP);
                set_sck(tgt, ~cpol);
                if (i == nbits - 1) -> last_ev;
                #(HP);
                set_sck(tgt, cpol);
            end else begin
                set_sck(tgt, ~cpol); set_mosi(tgt, b); #(HP);
                set_sck(tgt, cpol);
                if (i == nbits - 1) -> last_ev;
                #(HP);
            end
        end
        if (end_sel) begin #(HP); set_csn(tgt, 1'b1); #(HP); end
        $display("sent 0x%04h (%0d bits) to target %0d", data, nbits, tgt);
    endtask

    task automatic pop_word();
        @(posedge clock); #1 rdEn = 1'b1;
        @(posedge clock); #1 rdEn = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clock);
        #2;
    endtask

    initial begin
        resetN = 1'b0; sck = 1'b0; mosi = 1'b0; csn = 1'b1;
        rdEn = 1'b0; clearOverrun = 1'b0;
        m_sck = M_CPOL; m_csn = 4'hF; m_mosi = 1'b0;

        // Scoreboard monitor: pops expected word whenever a read is accepted.
        fork
            forever begin
                @(negedge clock);
                if (resetN) begin
                    if (interupt) irq_cnt++;
                    if (frameError) fe_cnt++;
                    if (rdEn && valid) begin
                        if (exp_q.size() == 0) begin
                            check("pop_unexpected", {16'h0, rdData}, 32'hFFFF_FFFF);
                        end else begin
                            exp_w = exp_q.pop_front();
                            check("pop_data", {16'h0, rdData}, {16'h0, exp_w});
                            $display("pop 0x%04h expected 0x%04h", rdData, exp_w);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clock);
        #2 resetN = 1'b1;
        @(posedge clock); #2;
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_count", {29'h0, count}, 32'h0);
        check("rst_rddata", {16'h0, rdData}, 32'h0);
        check("rst_irq", {31'h0, interupt}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        check("rst_frame", {31'h0, frameError}, 32'h0);

        // Single word, mode 0
        exp_q.push_back(16'hA5C3);
        spi_send(-1, 1'b0, 1'b0, 16'hA5C3, 16, 1'b1, 1'b1);
        settle();
        check("w1_irq_cnt", irq_cnt, 1);
        check("w1_valid", {31'h0, valid}, 32'h1);
        check("w1_count", {29'h0, count}, 32'h1);
        check("w1_rddata", {16'h0, rdData}, 32'hA5C3);
        pop_word(); #1;
        check("w1_valid_after_pop", {31'h0, valid}, 32'h0);
        check("w1_rddata_empty", {16'h0, rdData}, 32'h0);

        // Back-to-back burst of five into DEPTH=4, fifth dropped
        for (int k = 0; k < 5; k++) begin
            if (k < 4) exp_q.push_back(16'h1111 * 16'(k + 1));
            spi_send(-1, 1'b0, 1'b0, 16'h1111 * 16'(k + 1), 16, k == 0, k == 4);
        end
        settle();
        check("b2b_irq_cnt", irq_cnt, 6);
        check("b2b_overrun", {31'h0, overrun}, 32'h1);
        check("b2b_count", {29'h0, count}, 32'h4);
        @(posedge clock); #1 clearOverrun = 1'b1;
        @(posedge clock); #1 clearOverrun = 1'b0;
        #1 check("b2b_overrun_clr", {31'h0, overrun}, 32'h0);
        repeat (4) pop_word();
        #1 check("b2b_drained", {29'h0, count}, 32'h0);

        // Full FIFO with a read in the very cycle the fifth word is written
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(16'h0A0A + 16'h0101 * 16'(k));
            spi_send(-1, 1'b0, 1'b0, 16'h0A0A + 16'h0101 * 16'(k), 16, k == 0, 1'b0);
        end
        exp_q.push_back(16'h0E0E);
        fork
            spi_send(-1, 1'b0, 1'b0, 16'h0E0E, 16, 1'b0, 1'b1);
            begin
                @(last_ev);
                repeat (2) @(posedge clock);
                #1 rdEn = 1'b1;
                @(posedge clock); #1 rdEn = 1'b0;
            end
        join
        settle();
        check("fullrd_irq_cnt", irq_cnt, 11);
        check("fullrd_count", {29'h0, count}, 32'h4);
        check("fullrd_overrun", {31'h0, overrun}, 32'h0);
        repeat (4) pop_word();
        #1 check("fullrd_drained", {29'h0, count}, 32'h0);

        // Truncated frame, then a clean word
        spi_send(-1, 1'b0, 1'b0, 16'hFFFF, 7, 1'b1, 1'b1);
        settle();
        check("frame_err_cnt", fe_cnt, 1);
        check("frame_count", {29'h0, count}, 32'h0);
        check("frame_irq_cnt", irq_cnt, 11);
        exp_q.push_back(16'h1234);
        spi_send(-1, 1'b0, 1'b0, 16'h1234, 16, 1'b1, 1'b1);
        settle();
        check("after_frame_count", {29'h0, count}, 32'h1);
        check("after_frame_data", {16'h0, rdData}, 32'h1234);
        pop_word();

        // Reset mid-word with two words queued (not expected to be read)
        spi_send(-1, 1'b0, 1'b0, 16'h3333, 16, 1'b1, 1'b0);
        spi_send(-1, 1'b0, 1'b0, 16'h4444, 16, 1'b0, 1'b0);
        spi_send(-1, 1'b0, 1'b0, 16'h5555, 5, 1'b0, 1'b0);
        @(posedge clock); #3 resetN = 1'b0;
        #1;
        check("amid_valid", {31'h0, valid}, 32'h0);
        check("amid_count", {29'h0, count}, 32'h0);
        check("amid_rddata", {16'h0, rdData}, 32'h0);
        check("amid_irq", {31'h0, interupt}, 32'h0);
        csn = 1'b1;
        #20 resetN = 1'b1;
        exp_q.push_back(16'h0F0F);
        spi_send(-1, 1'b0, 1'b0, 16'h0F0F, 16, 1'b1, 1'b1);
        settle();
        check("post_rst_count", {29'h0, count}, 32'h1);
        check("post_rst_data", {16'h0, rdData}, 32'h0F0F);
        pop_word();

        // Mode / bit-order sweep on the extra instances
        for (int k = 0; k < 4; k++) begin
            spi_send(k, M_CPOL[k], M_CPHA[k], 16'h0001, 16, 1'b1, 1'b1);
            settle();
            check($sformatf("mode%0d_valid", k), {31'h0, m_valid[k]}, 32'h1);
            check($sformatf("mode%0d_data", k), {16'h0, m_rd[k]},
                  (k == 3) ? 32'h8000 : 32'h0001);
        end

        repeat (3) @(posedge clock);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
